// File: rtl/sio_slave.sv
// SPI responder: oversamples sclk/cs/mosi in the clkin domain and shifts
// 1-16 bit MSB-first frames, reloading the transmit word at every frame start.
module sio_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clkin,
    input  logic        rst_n,
    input  logic [3:0]  bits,
    input  logic [15:0] tx_data,
    output logic        tx_load,
    output logic [15:0] rx_data,
    output logic        rx_valid,
    output logic        abort,
    output logic        busy,
    input  logic        sclk,
    input  logic        cs,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_dly_q;
    logic                   cs_dly_q;

    state_e      state_q;
    logic [3:0]  len_q;
    logic [3:0]  bitcnt_q;
    logic [15:0] txsh_q;
    logic [15:0] rxsh_q;
    logic [15:0] rx_data_q;
    logic        mid_q;
    logic        miso_q;
    logic        tx_load_q;
    logic        rx_valid_q;
    logic        done_q;
    logic        abort_q;

    logic        sclk_s;
    logic        cs_s;
    logic        mosi_s;
    logic        sclk_fall;
    logic        cs_fall;
    logic        cs_rise;
    logic [15:0] len_mask;
    logic [15:0] rx_word_d;

    // cs presets high so a released reset never fakes a frame start
    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_dly_q  <= 1'b0;
            cs_dly_q    <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_dly_q  <= sclk_s;
            cs_dly_q    <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_fall = sclk_dly_q & ~sclk_s;
    assign cs_fall   = cs_dly_q & ~cs_s;
    assign cs_rise   = ~cs_dly_q & cs_s;

    assign len_mask  = ~(16'hFFFE << len_q);
    assign rx_word_d = (rxsh_q | {15'h0000, mosi_s}) & len_mask;

    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            len_q      <= '0;
            bitcnt_q   <= '0;
            txsh_q     <= '0;
            rxsh_q     <= '0;
            rx_data_q  <= '0;
            mid_q      <= 1'b0;
            miso_q     <= 1'b0;
            tx_load_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            tx_load_q  <= 1'b0;
            abort_q    <= 1'b0;
            done_q     <= 1'b0;
            rx_valid_q <= done_q;
            unique case (state_q)
                IDLE: begin
                    miso_q <= 1'b0;
                    if (cs_fall) begin
                        len_q     <= bits;
                        bitcnt_q  <= bits;
                        txsh_q    <= tx_data;
                        tx_load_q <= 1'b1;
                        miso_q    <= tx_data[bits];
                        rxsh_q    <= '0;
                        mid_q     <= 1'b0;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // cs_rise takes priority; a coincident sclk edge is dropped
                    if (cs_rise) begin
                        state_q <= IDLE;
                        miso_q  <= 1'b0;
                        abort_q <= mid_q;
                        mid_q   <= 1'b0;
                    end else if (sclk_fall) begin
                        if (bitcnt_q != 4'd0) begin
                            rxsh_q[bitcnt_q] <= mosi_s;
                            mid_q            <= 1'b1;
                            bitcnt_q         <= bitcnt_q - 4'd1;
                            miso_q           <= txsh_q[bitcnt_q - 4'd1];
                        end else begin
                            rx_data_q <= rx_word_d;
                            done_q    <= 1'b1;
                            mid_q     <= 1'b0;
                            len_q     <= bits;
                            bitcnt_q  <= bits;
                            txsh_q    <= tx_data;
                            tx_load_q <= 1'b1;
                            miso_q    <= tx_data[bits];
                            rxsh_q    <= '0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_load  = tx_load_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign abort    = abort_q;
    assign busy     = ~cs_s;
    assign miso_oe  = ~cs_s;
    assign miso     = miso_q;

endmodule

// File: tb/tb_sio_slave.sv
// Scoreboard bench for sio_slave: a pin-level SPI master drives frames,
// expected words are queued at issue and checked by an rx_valid monitor.
module tb_sio_slave;

    logic        clkin = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  bits = 4'd0;
    logic [15:0] tx_data = 16'h0000;
    logic        tx_load;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        abort;
    logic        busy;
    logic        sclk = 1'b0;
    logic        cs = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
    logic        miso_oe;

    sio_slave #(.SYNC_STAGES(2)) dut (
        .clkin   (clkin),
        .rst_n   (rst_n),
        .bits    (bits),
        .tx_data (tx_data),
        .tx_load (tx_load),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .abort   (abort),
        .busy    (busy),
        .sclk    (sclk),
        .cs      (cs),
        .mosi    (mosi),
        .miso    (miso),
        .miso_oe (miso_oe)
    );

    always #5 clkin = ~clkin;

    int checks = 0;
    int errors = 0;
    int n_txload = 0;
    int n_abort = 0;
    int n_rxvalid = 0;
    int exp_txload = 0;
    int exp_abort = 0;
    int exp_rxvalid = 0;
    logic [15:0] exp_rx_q[$];
    logic [15:0] mon_exp;

    int          fb[4];
    logic [15:0] ft[4];
    logic [15:0] fm[4];

    // Monitor: every rx_valid pops one expected word
    always @(negedge clkin) begin
        if (tx_load) n_txload++;
        if (abort) n_abort++;
        if (rx_valid) begin
            n_rxvalid++;
            checks++;
            if (exp_rx_q.size() == 0) begin
                errors++;
                $display("FAIL rx_unexpected got %h expected none", rx_data);
            end else begin
                mon_exp = exp_rx_q.pop_front();
                if (rx_data !== mon_exp) begin
                    errors++;
                    $display("FAIL rx_data got %h expected %h", rx_data, mon_exp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clkin);
    endtask

    function automatic logic [15:0] lenmask(input int b);
        logic [15:0] all1;
        all1 = 16'hFFFF;
        return all1 >> (15 - b);
    endfunction

    task automatic xfer_bit(input logic mo, output logic mi);
        mosi = mo;
        sclk = 1'b1;
        wait_n(8);
        mi = miso;
        sclk = 1'b0;
        wait_n(8);
    endtask

    task automatic run_frame(input int b, input logic [15:0] mo_w,
                             output logic [15:0] mi_w);
        logic mi;
        mi_w = 16'h0000;
        for (int i = b; i >= 0; i--) begin
            xfer_bit(mo_w[i], mi);
            mi_w[i] = mi;
        end
    endtask

    // One cs-low session of nf back-to-back frames described by fb/ft/fm
    task automatic session(input int nf);
        logic [15:0] got;
        bits = 4'(fb[0]);
        tx_data = ft[0];
        cs = 1'b0;
        wait_n(8);
        exp_txload++;
        for (int k = 0; k < nf; k++) begin
            if (k + 1 < nf) begin
                bits = 4'(fb[k+1]);
                tx_data = ft[k+1];
            end else begin
                bits = 4'($urandom_range(0, 15));
                tx_data = 16'($urandom);
            end
            exp_rx_q.push_back(fm[k] & lenmask(fb[k]));
            exp_rxvalid++;
            run_frame(fb[k], fm[k], got);
            exp_txload++;
            chk("master_rx", got, ft[k] & lenmask(fb[k]));
        end
        cs = 1'b1;
        wait_n(8);
        chk("txload_cnt", n_txload, exp_txload);
        chk("rxvalid_cnt", n_rxvalid, exp_rxvalid);
    endtask

    task automatic start_partial(input int b, input int nbits);
        logic mi;
        bits = 4'(b);
        tx_data = 16'($urandom);
        cs = 1'b0;
        wait_n(8);
        exp_txload++;
        for (int i = 0; i < nbits; i++) xfer_bit(1'($urandom), mi);
    endtask

    initial begin
        @(negedge clkin);
        // Reset with cs low and sclk toggling
        rst_n = 1'b0;
        cs = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sclk = ~sclk;
            @(negedge clkin);
        end
        chk("rst_miso", miso, 0);
        chk("rst_miso_oe", miso_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {tx_load, rx_valid, abort}, 0);
        chk("rst_rx_data", rx_data, 0);
        cs = 1'b1;
        sclk = 1'b0;
        wait_n(3);
        rst_n = 1'b1;
        wait_n(8);
        chk("post_rst_cnt", n_txload + n_abort + n_rxvalid, 0);
        chk("post_rst_busy", busy, 0);

        // 8-bit frame
        fb[0] = 7; ft[0] = 16'h00A5; fm[0] = 16'h003C;
        session(1);
        chk("rx8_hold", rx_data, 16'h003C);

        // 16-bit back-to-back
        fb[0] = 15; ft[0] = 16'hBEEF; fm[0] = 16'hCAFE;
        fb[1] = 15; ft[1] = 16'h1234; fm[1] = 16'h0F0F;
        session(2);

        // Abort after 3 falls
        start_partial(7, 3);
        chk("abort_busy", busy, 1);
        cs = 1'b1;
        wait_n(8);
        exp_abort++;
        chk("abort_cnt", n_abort, exp_abort);
        chk("abort_rx_keep", rx_data, 16'h0F0F);
        chk("abort_miso", miso, 0);
        chk("abort_miso_oe", miso_oe, 0);
        chk("abort_txload", n_txload, exp_txload);

        // bits=0 boundaries
        fb[0] = 0; ft[0] = 16'hFFFE; fm[0] = 16'h0000;
        session(1);
        fb[0] = 0; ft[0] = 16'h0001; fm[0] = 16'h0001;
        session(1);
        chk("b0_rx", rx_data, 16'h0001);

        // cs_rise coincident with the final sclk fall
        start_partial(7, 7);
        mosi = 1'b1;
        sclk = 1'b1;
        wait_n(8);
        sclk = 1'b0;
        cs = 1'b1;
        wait_n(10);
        exp_abort++;
        chk("race_abort_cnt", n_abort, exp_abort);
        chk("race_rx_keep", rx_data, 16'h0001);
        chk("race_txload", n_txload, exp_txload);

        // Reset mid-frame, then a clean frame
        start_partial(7, 5);
        rst_n = 1'b0;
        cs = 1'b1;
        sclk = 1'b0;
        wait_n(3);
        rst_n = 1'b1;
        wait_n(8);
        chk("mrst_abort", n_abort, exp_abort);
        chk("mrst_rx", rx_data, 16'h0000);
        chk("mrst_busy", busy, 0);
        fb[0] = 7; ft[0] = 16'($urandom); fm[0] = 16'h0081;
        session(1);
        chk("mrst_rx_after", rx_data, 16'h0081);

        // Randomized sessions
        for (int s = 0; s < 20; s++) begin
            int nf;
            nf = $urandom_range(1, 3);
            for (int k = 0; k < nf; k++) begin
                fb[k] = $urandom_range(0, 15);
                ft[k] = 16'($urandom);
                fm[k] = 16'($urandom);
            end
            session(nf);
        end

        wait_n(10);
        chk("rx_queue_empty", exp_rx_q.size(), 0);
        chk("final_abort_cnt", n_abort, exp_abort);
        chk("final_txload_cnt", n_txload, exp_txload);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
